ram_ff_mp: RTL and testbench

Parametrised multi-port flip-flop RAM, the next generation of the team's dual-write/dual-read FF RAM. It provides NUM_WR write ports and NUM_RD read ports over a DEPTH x DATAWIDTH register array. Configurable options cover array reset mode, registered or combinational read, and read-during-write bypass, and the block flags same-address write collisions. It serves as a small register file or scratch store inside datapath blocks.

---
 rtl/ram_ff_pkg.sv | 48 ++++
 rtl/ram_ff_wr_arb.sv | 45 ++++
 rtl/ram_ff_mp.sv | 148 ++++++++++++++
 tb/tb_ram_ff_mp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_ff_pkg.sv
// Shared definitions for the multi-port flip-flop RAM: reset-mode enum,
// port-count limits, parameter sanity predicate and write-port priority select.
package ram_ff_pkg;

  localparam int MAX_WR   = 4;
  localparam int MAX_RD   = 8;
  localparam int WR_IDX_W = 2;

  typedef enum logic {
    RST_CLEAR = 1'b0,
    RST_NONE  = 1'b1
  } rst_mode_e;

  // True when every parameter lies inside the range the array supports.
  function automatic bit params_ok(
    input int datawidth,
    input int addrwidth,
    input int depth,
    input int num_wr,
    input int num_rd,
    input int rst_mode,
    input int rd_reg,
    input int bypass
  );
    bit ok;
    ok = 1'b1;
    if (datawidth < 1)                            ok = 1'b0;
    if (addrwidth < 1 || addrwidth > 16)          ok = 1'b0;
    if (depth < 2 || depth > (1 << addrwidth))    ok = 1'b0;
    if (num_wr < 1 || num_wr > MAX_WR)            ok = 1'b0;
    if (num_rd < 1 || num_rd > MAX_RD)            ok = 1'b0;
    if (rst_mode != int'(RST_CLEAR) && rst_mode != int'(RST_NONE)) ok = 1'b0;
    if (rd_reg != 0 && rd_reg != 1)               ok = 1'b0;
    if (bypass != 0 && bypass != 1)               ok = 1'b0;
    return ok;
  endfunction

  // Lowest-indexed set bit wins; returns 0 when nothing is set.
  function automatic logic [WR_IDX_W-1:0] first_winner(input logic [MAX_WR-1:0] hits);
    logic [WR_IDX_W-1:0] idx;
    idx = '0;
    for (int p = MAX_WR - 1; p >= 0; p--) begin
      if (hits[p]) idx = WR_IDX_W'(p);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_ff_wr_arb.sv
// Per-word write arbitration: decides which write port (if any) updates each
// word this cycle and flags cycles where several enabled ports hit one word.
module ram_ff_wr_arb
  import ram_ff_pkg::*;
#(
  parameter int ADDRWIDTH = 3,
  parameter int DEPTH     = 1 << ADDRWIDTH,
  parameter int NUM_WR    = 2
) (
  input  logic [NUM_WR-1:0]                en_w_n,
  input  logic [NUM_WR-1:0][ADDRWIDTH-1:0] addr_w,
  output logic [DEPTH-1:0]                 word_we,
  output logic [DEPTH-1:0][WR_IDX_W-1:0]   word_sel,
  output logic                             collision
);

  logic [DEPTH-1:0][MAX_WR-1:0] word_hits;

  // Which enabled ports address each in-range word; unused port slots stay 0.
  always_comb begin
    word_hits = '0;
    for (int w = 0; w < DEPTH; w++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (!en_w_n[p] && (addr_w[p] == ADDRWIDTH'(w))) begin
          word_hits[w][p] = 1'b1;
        end
      end
    end
  end

  // Enable, winning port and multi-hit detection per word.
  always_comb begin
    word_we   = '0;
    word_sel  = '0;
    collision = 1'b0;
    for (int w = 0; w < DEPTH; w++) begin
      word_we[w]  = |word_hits[w];
      word_sel[w] = first_winner(word_hits[w]);
      if (|(word_hits[w] & (word_hits[w] - MAX_WR'(1)))) begin
        collision = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_ff_mp.sv
// Multi-port flip-flop RAM: NUM_WR write ports and NUM_RD read ports over a
// DEPTH x DATAWIDTH register array, with optional array reset, registered
// read, read-during-write bypass, and registered collision / address flags.
module ram_ff_mp
  import ram_ff_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 3,
  parameter int DEPTH     = 1 << ADDRWIDTH,
  parameter int NUM_WR    = 2,
  parameter int NUM_RD    = 2,
  parameter int RST_MODE  = 0,
  parameter int RD_REG    = 0,
  parameter int BYPASS    = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_WR-1:0]                en_w_n,
  input  logic [NUM_WR-1:0][ADDRWIDTH-1:0] addr_w,
  input  logic [NUM_WR-1:0][DATAWIDTH-1:0] data_w,
  input  logic [NUM_RD-1:0]                en_r_n,
  input  logic [NUM_RD-1:0][ADDRWIDTH-1:0] addr_r,
  output logic [NUM_RD-1:0][DATAWIDTH-1:0] data_r,
  output logic                             wr_collision,
  output logic                             addr_err
);

  if (!params_ok(DATAWIDTH, ADDRWIDTH, DEPTH, NUM_WR, NUM_RD, RST_MODE, RD_REG, BYPASS)) begin : g_param_err
    $error("ram_ff_mp: parameter out of supported range");
  end

  logic [DATAWIDTH-1:0]                 mem [DEPTH];
  logic [DEPTH-1:0]                     word_we;
  logic [DEPTH-1:0][WR_IDX_W-1:0]       word_sel;
  logic [DEPTH-1:0][DATAWIDTH-1:0]      word_data;
  logic [NUM_RD-1:0][DATAWIDTH-1:0]     rd_val;
  logic                                 collision_d;
  logic                                 addr_err_d;

  function automatic logic in_range(input logic [ADDRWIDTH-1:0] a);
    return {1'b0, a} < (ADDRWIDTH + 1)'(DEPTH);
  endfunction

  ram_ff_wr_arb #(
    .ADDRWIDTH (ADDRWIDTH),
    .DEPTH     (DEPTH),
    .NUM_WR    (NUM_WR)
  ) u_wr_arb (
    .en_w_n    (en_w_n),
    .addr_w    (addr_w),
    .word_we   (word_we),
    .word_sel  (word_sel),
    .collision (collision_d)
  );

  // Route the winning port's data to each word; shared by the array and bypass.
  always_comb begin
    word_data = '0;
    for (int w = 0; w < DEPTH; w++) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (word_sel[w] == WR_IDX_W'(p)) begin
          word_data[w] = data_w[p];
        end
      end
    end
  end

  // Any enabled write or read port addressing beyond the array.
  always_comb begin
    addr_err_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (!en_w_n[p] && !in_range(addr_w[p])) addr_err_d = 1'b1;
    end
    for (int i = 0; i < NUM_RD; i++) begin
      if (!en_r_n[i] && !in_range(addr_r[i])) addr_err_d = 1'b1;
    end
  end

  // Read mux per port: out-of-range and disabled ports yield 0; bypass picks
  // the word being written this cycle, but only while out of reset so a
  // gated write never leaks through.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!en_r_n[i]) begin
        for (int w = 0; w < DEPTH; w++) begin
          if (addr_r[i] == ADDRWIDTH'(w)) begin
            if ((BYPASS != 0) && rst_n && word_we[w]) begin
              rd_val[i] = word_data[w];
            end else begin
              rd_val[i] = mem[w];
            end
          end
        end
      end
    end
  end

  if (RST_MODE == int'(RST_CLEAR)) begin : g_mem_clear
    // Array cleared asynchronously on reset, then written by the winning ports.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int w = 0; w < DEPTH; w++) mem[w] <= '0;
      end else begin
        for (int w = 0; w < DEPTH; w++) begin
          if (word_we[w]) mem[w] <= word_data[w];
        end
      end
    end
  end else begin : g_mem_noreset
    // Array without reset; writes are still dropped while reset is held.
    always_ff @(posedge clk) begin
      for (int w = 0; w < DEPTH; w++) begin
        if (rst_n && word_we[w]) mem[w] <= word_data[w];
      end
    end
  end

  if (RD_REG != 0) begin : g_rd_reg
    // Registered read: enabled ports load at the edge, disabled ports hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_r <= '0;
      end else begin
        for (int i = 0; i < NUM_RD; i++) begin
          if (!en_r_n[i]) data_r[i] <= rd_val[i];
        end
      end
    end
  end else begin : g_rd_comb
    // Combinational read straight from the mux.
    always_comb begin
      data_r = rd_val;
    end
  end

  // One-cycle status pulses for the previous cycle's collisions and bad addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_collision <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      wr_collision <= collision_d;
      addr_err     <= addr_err_d;
    end
  end

endmodule

// File: tb/tb_ram_ff_mp.sv
// Directed bench for ram_ff_mp: three instances share one stimulus stream
// (A: defaults, B: registered read + bypass, C: DEPTH=6, no array reset,
// combinational bypass) and are compared against hand-computed values.
module tb_ram_ff_mp;

  logic            clk;
  logic            rst_n;
  logic [1:0]      en_w_n;
  logic [1:0][2:0] addr_w;
  logic [1:0][7:0] data_w;
  logic [1:0]      en_r_n;
  logic [1:0][2:0] addr_r;

  logic [1:0][7:0] data_r_a, data_r_b, data_r_c;
  logic            wr_coll_a, wr_coll_b, wr_coll_c;
  logic            addr_err_a, addr_err_b, addr_err_c;

  int checks;
  int errors;

  ram_ff_mp dut_a (
    .clk (clk), .rst_n (rst_n),
    .en_w_n (en_w_n), .addr_w (addr_w), .data_w (data_w),
    .en_r_n (en_r_n), .addr_r (addr_r), .data_r (data_r_a),
    .wr_collision (wr_coll_a), .addr_err (addr_err_a)
  );

  ram_ff_mp #(.RD_REG (1), .BYPASS (1)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .en_w_n (en_w_n), .addr_w (addr_w), .data_w (data_w),
    .en_r_n (en_r_n), .addr_r (addr_r), .data_r (data_r_b),
    .wr_collision (wr_coll_b), .addr_err (addr_err_b)
  );

  ram_ff_mp #(.DEPTH (6), .RST_MODE (1), .BYPASS (1)) dut_c (
    .clk (clk), .rst_n (rst_n),
    .en_w_n (en_w_n), .addr_w (addr_w), .data_w (data_w),
    .en_r_n (en_r_n), .addr_r (addr_r), .data_r (data_r_c),
    .wr_collision (wr_coll_c), .addr_err (addr_err_c)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(
    input logic [1:0] wen, input logic [2:0] wa0, input logic [7:0] wd0,
    input logic [2:0] wa1, input logic [7:0] wd1,
    input logic [1:0] ren, input logic [2:0] ra0, input logic [2:0] ra1
  );
    @(negedge clk);
    en_w_n    = wen;
    addr_w[0] = wa0;
    data_w[0] = wd0;
    addr_w[1] = wa1;
    data_w[1] = wd1;
    en_r_n    = ren;
    addr_r[0] = ra0;
    addr_r[1] = ra1;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Linear directed sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    en_w_n = 2'b11;
    addr_w = '0;
    data_w = '0;
    en_r_n = 2'b11;
    addr_r = '0;

    #1 rst_n = 1'b0;
    #2;
    $display("[TB] reset asserted");
    checkOutput("rst_coll_a", {7'd0, wr_coll_a}, 8'h00);
    checkOutput("rst_aerr_a", {7'd0, addr_err_a}, 8'h00);
    checkOutput("rst_b_r0", data_r_b[0], 8'h00);
    checkOutput("rst_b_r1", data_r_b[1], 8'h00);
    checkOutput("rst_aerr_b", {7'd0, addr_err_b}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 8; a += 2) begin
      applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 3'(a), 3'(a + 1));
      checkOutput("clr_a_r0", data_r_a[0], 8'h00);
      checkOutput("clr_a_r1", data_r_a[1], 8'h00);
      tick();
      checkOutput("clr_b_r0", data_r_b[0], 8'h00);
      checkOutput("clr_b_r1", data_r_b[1], 8'h00);
    end
    checkOutput("clr_coll_a", {7'd0, wr_coll_a}, 8'h00);
    checkOutput("clr_aerr_a", {7'd0, addr_err_a}, 8'h00);

    $display("[TB] dual write A5@3 / 5A@6");
    applyStimulus(2'b00, 3'd3, 8'hA5, 3'd6, 8'h5A, 2'b11, 3'd0, 3'd0);
    tick();
    checkOutput("dw_coll_a", {7'd0, wr_coll_a}, 8'h00);
    checkOutput("dw_aerr_a", {7'd0, addr_err_a}, 8'h00);
    checkOutput("dw_aerr_c_edge", {7'd0, addr_err_c}, 8'h01);

    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 3'd3, 3'd6);
    checkOutput("dw_a_r0", data_r_a[0], 8'hA5);
    checkOutput("dw_a_r1", data_r_a[1], 8'h5A);
    checkOutput("dw_b_r0_pre", data_r_b[0], 8'h00);
    checkOutput("dw_c_r0", data_r_c[0], 8'hA5);
    checkOutput("dw_c_r1_oor", data_r_c[1], 8'h00);
    tick();
    checkOutput("dw_b_r0", data_r_b[0], 8'hA5);
    checkOutput("dw_b_r1", data_r_b[1], 8'h5A);
    checkOutput("dw_aerr_c_rd", {7'd0, addr_err_c}, 8'h01);
    checkOutput("dw_aerr_a2", {7'd0, addr_err_a}, 8'h00);

    $display("[TB] collision 11/22 @2");
    applyStimulus(2'b00, 3'd2, 8'h11, 3'd2, 8'h22, 2'b11, 3'd0, 3'd0);
    tick();
    checkOutput("col_coll_a", {7'd0, wr_coll_a}, 8'h01);
    checkOutput("col_coll_c", {7'd0, wr_coll_c}, 8'h01);
    checkOutput("col_aerr_c", {7'd0, addr_err_c}, 8'h00);

    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 3'd2, 3'd3);
    checkOutput("col_a_r0", data_r_a[0], 8'h11);
    checkOutput("col_a_r1", data_r_a[1], 8'hA5);
    checkOutput("col_coll_a_hold", {7'd0, wr_coll_a}, 8'h01);
    tick();
    checkOutput("col_coll_a_drop", {7'd0, wr_coll_a}, 8'h00);
    checkOutput("col_b_r0", data_r_b[0], 8'h11);

    $display("[TB] read-during-write @4");
    applyStimulus(2'b10, 3'd4, 8'h33, 3'd0, 8'h00, 2'b11, 3'd0, 3'd0);
    tick();
    applyStimulus(2'b10, 3'd4, 8'h44, 3'd0, 8'h00, 2'b10, 3'd4, 3'd0);
    checkOutput("rdw_a_old", data_r_a[0], 8'h33);
    checkOutput("rdw_c_byp", data_r_c[0], 8'h44);
    checkOutput("rdw_a_r1_dis", data_r_a[1], 8'h00);
    tick();
    checkOutput("rdw_b_byp", data_r_b[0], 8'h44);
    checkOutput("rdw_a_after", data_r_a[0], 8'h44);
    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b10, 3'd4, 3'd0);
    checkOutput("rdw_a_next", data_r_a[0], 8'h44);
    checkOutput("rdw_c_next", data_r_c[0], 8'h44);
    tick();
    checkOutput("rdw_b_next", data_r_b[0], 8'h44);

    $display("[TB] out-of-range write 77@7");
    applyStimulus(2'b10, 3'd7, 8'h77, 3'd0, 8'h00, 2'b11, 3'd0, 3'd0);
    tick();
    checkOutput("oor_aerr_c", {7'd0, addr_err_c}, 8'h01);
    checkOutput("oor_aerr_a", {7'd0, addr_err_a}, 8'h00);
    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b11, 3'd0, 3'd0);
    tick();
    checkOutput("oor_aerr_c_drop", {7'd0, addr_err_c}, 8'h00);
    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b00, 3'd7, 3'd3);
    checkOutput("oor_c_r0", data_r_c[0], 8'h00);
    checkOutput("oor_c_r1", data_r_c[1], 8'hA5);
    checkOutput("oor_a_r0", data_r_a[0], 8'h77);
    tick();
    checkOutput("oor_b_r0", data_r_b[0], 8'h77);
    checkOutput("oor_b_r1", data_r_b[1], 8'hA5);
    checkOutput("oor_aerr_c_rd", {7'd0, addr_err_c}, 8'h01);

    $display("[TB] mid-stream reset");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_b_r0", data_r_b[0], 8'h00);
    checkOutput("mr_b_r1", data_r_b[1], 8'h00);
    checkOutput("mr_a_r1", data_r_a[1], 8'h00);
    checkOutput("mr_aerr_c", {7'd0, addr_err_c}, 8'h00);
    applyStimulus(2'b10, 3'd1, 8'h99, 3'd0, 8'h00, 2'b10, 3'd1, 3'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mr_a_lost", data_r_a[0], 8'h00);
    tick();
    checkOutput("mr_a_land", data_r_a[0], 8'h99);
    checkOutput("mr_b_land", data_r_b[0], 8'h99);

    applyStimulus(2'b11, 3'd0, 8'h00, 3'd0, 8'h00, 2'b11, 3'd0, 3'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
